// File: rtl/decode_round_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// decode_round_scheduler_pkg
//
// Purpose:
//   Shared definitions for the decode round scheduler. It holds the decoding
//   controller's global stage encodings, which the controller also uses, and
//   the scheduler's own state encoding.
//
// Contents:
//   STAGE_WIDTH, STAGE_*  : controller global stage encodings
//   sched_state_t         : scheduler FSM states (S_IDLE .. S_DONE, 3 bits)
//   stage_is_finished()   : true when a stage means the round has ended
// ----------------------------------------------------------------------------
package decode_round_scheduler_pkg;

    localparam int STAGE_WIDTH = 3;

    localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                = 3'd0;
    localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = 3'd1;
    localparam logic [STAGE_WIDTH-1:0] STAGE_GROW                = 3'd2;
    localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE               = 3'd3;
    localparam logic [STAGE_WIDTH-1:0] STAGE_PEELING             = 3'd4;
    localparam logic [STAGE_WIDTH-1:0] STAGE_RESULT_VALID        = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_START      = 3'd1,
        S_WAIT_LEAVE = 3'd2,
        S_RUN        = 3'd3,
        S_ABORT      = 3'd4,
        S_DONE       = 3'd5
    } sched_state_t;

    // The controller signals the end of a round either by going back to idle
    // or by parking in the result-valid stage.
    function automatic logic stage_is_finished(input logic [STAGE_WIDTH-1:0] stage);
        return (stage == STAGE_IDLE) || (stage == STAGE_RESULT_VALID);
    endfunction

endpackage

// File: rtl/decode_round_scheduler_rr_arbiter.sv
// ----------------------------------------------------------------------------
// decode_round_scheduler_rr_arbiter
//
// Purpose:
//   Purely combinational round-robin pick. The search starts at the index
//   after rr_ptr, wraps modulo NUM_REQ, and returns the first requester whose
//   req bit is set. The scheduler owns rr_ptr and all other registers.
//
// Ports:
//   req        in  NUM_REQ    level requests
//   rr_ptr     in  IDX_WIDTH  index of the most recent winner
//   winner     out NUM_REQ    one-hot winner (all zero when req is zero)
//   winner_idx out IDX_WIDTH  binary index of the winner
// ----------------------------------------------------------------------------
module decode_round_scheduler_rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [IDX_WIDTH-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]   winner,
    output logic [IDX_WIDTH-1:0] winner_idx
);

    logic                 hit;
    logic [IDX_WIDTH-1:0] cand_idx;

    // Offsets 1..NUM_REQ make rr_ptr itself the lowest-priority candidate.
    // The last offset wraps back to rr_ptr, so a single active requester can
    // win again.
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        hit        = 1'b0;
        cand_idx   = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand_idx = IDX_WIDTH'((int'(rr_ptr) + off) % NUM_REQ);
            if (!hit && req[cand_idx]) begin
                hit              = 1'b1;
                winner_idx       = cand_idx;
                winner[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/decode_round_scheduler.sv
// ----------------------------------------------------------------------------
// decode_round_scheduler
//
// Purpose:
//   Shares one decoding controller among NUM_REQ syndrome sources. The
//   scheduler picks a source round-robin and pulses new_round_start. It then
//   follows the controller's global stage until the round ends, and returns
//   the iteration and cycle counts to the granted source. A per-round
//   watchdog aborts a round that never leaves idle or that runs too long.
//
// Ports:
//   clk                in   system clock
//   reset              in   asynchronous reset, active low
//   sched_enable       in   gates new grants only; a round in flight completes
//   req                in   level request per source
//   grant              out  one-hot owner of the decoder
//   grant_valid        out  high while grant is non-zero
//   new_round_start    out  one-cycle start pulse to the controller
//   global_stage       in   controller stage
//   iteration_counter  in   controller iteration count
//   cycle_counter      in   controller cycle count
//   decoder_abort      out  one-cycle abort pulse (watchdog or start timeout)
//   done               out  one-cycle pulse to the granted source at round end
//   result_iterations  out  iteration count, valid with done, held until the next done
//   result_cycles      out  cycle count, valid with done, held until the next done
//   result_timeout     out  1 when the round was aborted
//   rounds_completed   out  rounds ended without abort (wraps)
//   rounds_aborted     out  aborted rounds (saturates)
//
// Timing:
//   Every output is a register, so each pulse is set on the edge that enters
//   its state. new_round_start is high during S_START. decoder_abort is high
//   during S_ABORT. done is high during S_DONE, and grant drops on that same
//   edge. wd_cnt is 1 in the start-pulse cycle and counts up by one every
//   cycle after it. Its value therefore gives the cycle number of the round.
// ----------------------------------------------------------------------------
module decode_round_scheduler
    import decode_round_scheduler_pkg::*;
#(
    parameter int NUM_REQ                 = 4,
    parameter int ITERATION_COUNTER_WIDTH = 8,
    parameter int START_TIMEOUT           = 4,
    parameter int MAX_ROUND_CYCLES        = 1024
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               sched_enable,
    input  logic [NUM_REQ-1:0]                 req,
    output logic [NUM_REQ-1:0]                 grant,
    output logic                               grant_valid,
    output logic                               new_round_start,
    input  logic [STAGE_WIDTH-1:0]             global_stage,
    input  logic [ITERATION_COUNTER_WIDTH-1:0] iteration_counter,
    input  logic [31:0]                        cycle_counter,
    output logic                               decoder_abort,
    output logic [NUM_REQ-1:0]                 done,
    output logic [ITERATION_COUNTER_WIDTH-1:0] result_iterations,
    output logic [31:0]                        result_cycles,
    output logic                               result_timeout,
    output logic [31:0]                        rounds_completed,
    output logic [15:0]                        rounds_aborted
);

    localparam int IDX_WIDTH = $clog2(NUM_REQ);
    localparam int WD_WIDTH  = $clog2(MAX_ROUND_CYCLES + 1);

    localparam logic [WD_WIDTH-1:0] WD_START_LIMIT = WD_WIDTH'(START_TIMEOUT);
    localparam logic [WD_WIDTH-1:0] WD_ROUND_LIMIT = WD_WIDTH'(MAX_ROUND_CYCLES);

    sched_state_t         state;
    logic [IDX_WIDTH-1:0] rr_ptr;
    logic [WD_WIDTH-1:0]  wd_cnt;

    logic [NUM_REQ-1:0]   arb_winner;
    logic [IDX_WIDTH-1:0] arb_idx;

    decode_round_scheduler_rr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_rr_arbiter (
        .req        (req),
        .rr_ptr     (rr_ptr),
        .winner     (arb_winner),
        .winner_idx (arb_idx)
    );

    // Scheduler FSM with registered outputs. The pulse outputs default low
    // every cycle. A state that needs a pulse in the next cycle sets it on
    // its exit edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= S_IDLE;
            rr_ptr            <= IDX_WIDTH'(NUM_REQ - 1);
            wd_cnt            <= '0;
            grant             <= '0;
            grant_valid       <= 1'b0;
            new_round_start   <= 1'b0;
            decoder_abort     <= 1'b0;
            done              <= '0;
            result_iterations <= '0;
            result_cycles     <= '0;
            result_timeout    <= 1'b0;
            rounds_completed  <= '0;
            rounds_aborted    <= '0;
        end else begin
            new_round_start <= 1'b0;
            decoder_abort   <= 1'b0;
            done            <= '0;

            case (state)
                S_IDLE: begin
                    if (sched_enable && (|req)) begin
                        grant           <= arb_winner;
                        grant_valid     <= 1'b1;
                        rr_ptr          <= arb_idx;
                        new_round_start <= 1'b1;
                        wd_cnt          <= WD_WIDTH'(1);
                        state           <= S_START;
                    end
                end

                S_START: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    state  <= S_WAIT_LEAVE;
                end

                // wd_cnt is held on the abort path, so the abort report
                // carries the exact cycle that tripped the limit.
                S_WAIT_LEAVE: begin
                    if (global_stage != STAGE_IDLE) begin
                        wd_cnt <= wd_cnt + 1'b1;
                        state  <= S_RUN;
                    end else if (wd_cnt >= WD_START_LIMIT) begin
                        decoder_abort <= 1'b1;
                        state         <= S_ABORT;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end

                // Completion is tested before the watchdog, so a round that
                // ends on the last allowed cycle still counts as completed.
                S_RUN: begin
                    if (stage_is_finished(global_stage)) begin
                        result_iterations <= iteration_counter;
                        result_cycles     <= cycle_counter;
                        result_timeout    <= 1'b0;
                        done              <= grant;
                        grant             <= '0;
                        grant_valid       <= 1'b0;
                        state             <= S_DONE;
                    end else if (wd_cnt >= WD_ROUND_LIMIT) begin
                        decoder_abort <= 1'b1;
                        state         <= S_ABORT;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end

                S_ABORT: begin
                    result_iterations <= iteration_counter;
                    result_cycles     <= 32'(wd_cnt);
                    result_timeout    <= 1'b1;
                    if (rounds_aborted != 16'hFFFF) begin
                        rounds_aborted <= rounds_aborted + 16'd1;
                    end
                    done        <= grant;
                    grant       <= '0;
                    grant_valid <= 1'b0;
                    state       <= S_DONE;
                end

                S_DONE: begin
                    if (!result_timeout) begin
                        rounds_completed <= rounds_completed + 32'd1;
                    end
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decode_round_scheduler.sv
// ----------------------------------------------------------------------------
// tb_decode_round_scheduler
//
// Purpose:
//   Directed testbench for decode_round_scheduler, built with
//   MAX_ROUND_CYCLES = 64. A small controller model reacts to
//   new_round_start and decoder_abort. The model's leave cycle, return cycle
//   and result values come from config variables. Its cycle index k is 0 in
//   the start-pulse cycle. A monitor records pulses and the cycle on which
//   each one appears.
// ----------------------------------------------------------------------------
module tb_decode_round_scheduler;
    import decode_round_scheduler_pkg::*;

    logic                   clk               = 1'b0;
    logic                   reset             = 1'b0;
    logic                   sched_enable      = 1'b0;
    logic [3:0]             req               = 4'b0000;
    logic [STAGE_WIDTH-1:0] global_stage      = STAGE_IDLE;
    logic [7:0]             iteration_counter = 8'h00;
    logic [31:0]            cycle_counter     = 32'h0;

    logic [3:0]  grant;
    logic        grant_valid;
    logic        new_round_start;
    logic        decoder_abort;
    logic [3:0]  done;
    logic [7:0]  result_iterations;
    logic [31:0] result_cycles;
    logic        result_timeout;
    logic [31:0] rounds_completed;
    logic [15:0] rounds_aborted;

    int checks   = 0;
    int failures = 0;

    decode_round_scheduler #(
        .NUM_REQ                 (4),
        .ITERATION_COUNTER_WIDTH (8),
        .START_TIMEOUT           (4),
        .MAX_ROUND_CYCLES        (64)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .sched_enable      (sched_enable),
        .req               (req),
        .grant             (grant),
        .grant_valid       (grant_valid),
        .new_round_start   (new_round_start),
        .global_stage      (global_stage),
        .iteration_counter (iteration_counter),
        .cycle_counter     (cycle_counter),
        .decoder_abort     (decoder_abort),
        .done              (done),
        .result_iterations (result_iterations),
        .result_cycles     (result_cycles),
        .result_timeout    (result_timeout),
        .rounds_completed  (rounds_completed),
        .rounds_aborted    (rounds_aborted)
    );

    always #5 clk = ~clk;

    // Controller model config. A value of -1 means the event never happens.
    int          ctrl_leave_k = 1;
    int          ctrl_ret_k   = 10;
    logic [7:0]  ctrl_iter    = 8'd0;
    logic [31:0] ctrl_cyc     = 32'd0;
    bit          ctrl_active  = 1'b0;
    int          ctrl_k       = 0;

    // Controller model. While a round runs it shows fixed marker counts. The
    // real counts appear only on the cycle it returns to idle.
    always @(negedge clk) begin
        if (!reset) begin
            ctrl_active       = 1'b0;
            ctrl_k            = 0;
            global_stage      = STAGE_IDLE;
            iteration_counter = 8'h00;
            cycle_counter     = 32'h0;
        end else if (new_round_start) begin
            ctrl_active       = 1'b1;
            ctrl_k            = 0;
            global_stage      = STAGE_IDLE;
            iteration_counter = 8'hEE;
            cycle_counter     = 32'hDEADBEEF;
        end else if (decoder_abort) begin
            ctrl_active  = 1'b0;
            global_stage = STAGE_IDLE;
        end else if (ctrl_active) begin
            ctrl_k++;
            if (ctrl_k == ctrl_leave_k) global_stage = STAGE_GROW;
            if (ctrl_k == ctrl_ret_k) begin
                global_stage      = STAGE_IDLE;
                iteration_counter = ctrl_iter;
                cycle_counter     = ctrl_cyc;
                ctrl_active       = 1'b0;
            end
        end
    end

    // Pulse monitor, sampled on the falling edge.
    int          cyc         = 0;
    int          start_count = 0;
    int          abort_count = 0;
    int          done_count  = 0;
    int          last_abort_cyc = 0;
    logic [3:0]  start_grants[$];
    int          start_cycs[$];
    int          done_cycs[$];
    logic [3:0]  last_done        = 4'b0;
    logic [7:0]  done_iter        = 8'h0;
    logic [31:0] done_cycles      = 32'h0;
    logic        done_to          = 1'b0;
    logic        done_grant_valid = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (new_round_start) begin
            start_count++;
            start_grants.push_back(grant);
            start_cycs.push_back(cyc);
        end
        if (decoder_abort) begin
            abort_count++;
            last_abort_cyc = cyc;
        end
        if (done != 4'b0) begin
            done_count++;
            done_cycs.push_back(cyc);
            last_done        = done;
            done_iter        = result_iterations;
            done_cycles      = result_cycles;
            done_to          = result_timeout;
            done_grant_valid = grant_valid;
        end
    end

    // Advance to just after a falling edge, so the monitor has already run.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_start(input int budget, input string name);
        int base;
        int n;
        base = start_count;
        n    = 0;
        while (start_count == base && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (start_count == base) begin
            failures++;
            $display("[TB] FAIL %s: no start pulse within %0d cycles (required one)", name, budget);
        end
    endtask

    task automatic wait_done(input int budget, input string name);
        int base;
        int n;
        base = done_count;
        n    = 0;
        while (done_count == base && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (done_count == base) begin
            failures++;
            $display("[TB] FAIL %s: no done pulse within %0d cycles (required one)", name, budget);
        end
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        req          = 4'b0000;
        sched_enable = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if ({grant, grant_valid, new_round_start, decoder_abort, done} !== 11'b0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl: got %b required 0", {grant, grant_valid, new_round_start, decoder_abort, done});
        end
        checks++;
        if ({result_iterations, result_cycles, result_timeout, rounds_completed, rounds_aborted} !== 89'b0) begin
            failures++;
            $display("[TB] FAIL reset_results: got %h required 0", {result_iterations, result_cycles, result_timeout, rounds_completed, rounds_aborted});
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_round();
        int sb;
        sb = start_grants.size();
        ctrl_leave_k = 1;
        ctrl_ret_k   = 40;
        ctrl_iter    = 8'd3;
        ctrl_cyc     = 32'd40;
        sched_enable = 1'b1;
        req          = 4'b0010;
        wait_done(200, "single_done");
        req = 4'b0000;
        checks++;
        if (start_grants.size() - sb != 1) begin
            failures++;
            $display("[TB] FAIL single_starts: got %0d required 1", start_grants.size() - sb);
        end
        checks++;
        if (start_grants[sb] !== 4'b0010) begin
            failures++;
            $display("[TB] FAIL single_grant: got %b required 0010", start_grants[sb]);
        end
        checks++;
        if (last_done !== 4'b0010) begin
            failures++;
            $display("[TB] FAIL single_done_vec: got %b required 0010", last_done);
        end
        checks++;
        if (done_iter !== 8'd3 || done_cycles !== 32'd40 || done_to !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_results: got iter=%0d cyc=%0d to=%0d required 3/40/0", done_iter, done_cycles, done_to);
        end
        checks++;
        if (done_grant_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_grant_clear: got grant_valid=%0d with done, required 0", done_grant_valid);
        end
        tick();
        checks++;
        if (rounds_completed !== 32'd1 || rounds_aborted !== 16'd0) begin
            failures++;
            $display("[TB] FAIL single_counts: got completed=%0d aborted=%0d required 1/0", rounds_completed, rounds_aborted);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_order [5];
        int sb;
        int db;
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        sb = start_grants.size();
        db = done_cycs.size();
        ctrl_leave_k = 1;
        ctrl_ret_k   = 5;
        ctrl_iter    = 8'd1;
        ctrl_cyc     = 32'd5;
        sched_enable = 1'b1;
        req          = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            wait_done(100, "rr_done");
        end
        req = 4'b0000;
        tick();
        tick();
        checks++;
        if (start_grants.size() - sb != 5) begin
            failures++;
            $display("[TB] FAIL rr_starts: got %0d required 5", start_grants.size() - sb);
        end
        for (int r = 0; r < 5; r++) begin
            checks++;
            if (start_grants[sb + r] !== exp_order[r]) begin
                failures++;
                $display("[TB] FAIL rr_order[%0d]: got %b required %b", r, start_grants[sb + r], exp_order[r]);
            end
        end
        // Back-to-back: done in S_DONE, grant in S_IDLE, start pulse one cycle later.
        checks++;
        if (start_cycs[sb + 1] - done_cycs[db] != 2) begin
            failures++;
            $display("[TB] FAIL rr_back_to_back: got gap %0d required 2", start_cycs[sb + 1] - done_cycs[db]);
        end
        checks++;
        if (rounds_completed !== 32'd5) begin
            failures++;
            $display("[TB] FAIL rr_completed: got %0d required 5", rounds_completed);
        end
    endtask

    task automatic test_start_timeout();
        int sb;
        int ab;
        do_reset();
        sb = start_cycs.size();
        ab = abort_count;
        ctrl_leave_k = -1;
        ctrl_ret_k   = -1;
        sched_enable = 1'b1;
        req          = 4'b0001;
        wait_done(50, "timeout_done");
        req = 4'b0000;
        checks++;
        if (abort_count - ab != 1 || last_abort_cyc - start_cycs[sb] != 4) begin
            failures++;
            $display("[TB] FAIL timeout_abort: got aborts=%0d delay=%0d required 1/4", abort_count - ab, last_abort_cyc - start_cycs[sb]);
        end
        checks++;
        if (last_done !== 4'b0001 || done_to !== 1'b1) begin
            failures++;
            $display("[TB] FAIL timeout_done: got done=%b to=%0d required 0001/1", last_done, done_to);
        end
        checks++;
        if (done_cycles !== 32'd4 || done_iter !== 8'hEE) begin
            failures++;
            $display("[TB] FAIL timeout_results: got cyc=%0d iter=%h required 4/ee", done_cycles, done_iter);
        end
        tick();
        checks++;
        if (rounds_aborted !== 16'd1 || rounds_completed !== 32'd0) begin
            failures++;
            $display("[TB] FAIL timeout_counts: got aborted=%0d completed=%0d required 1/0", rounds_aborted, rounds_completed);
        end
    endtask

    task automatic test_watchdog();
        int sb;
        int ab;
        do_reset();
        sb = start_cycs.size();
        ab = abort_count;
        ctrl_leave_k = 1;
        ctrl_ret_k   = -1;
        sched_enable = 1'b1;
        req          = 4'b0100;
        wait_done(200, "wd_done");
        req = 4'b0000;
        checks++;
        if (abort_count - ab != 1 || last_abort_cyc - start_cycs[sb] != 64) begin
            failures++;
            $display("[TB] FAIL wd_abort: got aborts=%0d delay=%0d required 1/64", abort_count - ab, last_abort_cyc - start_cycs[sb]);
        end
        checks++;
        if (last_done !== 4'b0100 || done_to !== 1'b1 || done_cycles !== 32'd64) begin
            failures++;
            $display("[TB] FAIL wd_results: got done=%b to=%0d cyc=%0d required 0100/1/64", last_done, done_to, done_cycles);
        end
        tick();

        // The controller returns to idle in the very cycle the watchdog would fire.
        ab = abort_count;
        ctrl_leave_k = 1;
        ctrl_ret_k   = 63;
        ctrl_iter    = 8'd9;
        ctrl_cyc     = 32'd63;
        req          = 4'b0100;
        wait_done(200, "wd_edge_done");
        req = 4'b0000;
        checks++;
        if (abort_count != ab || done_to !== 1'b0) begin
            failures++;
            $display("[TB] FAIL wd_edge: got aborts=%0d to=%0d required 0/0", abort_count - ab, done_to);
        end
        checks++;
        if (done_iter !== 8'd9 || done_cycles !== 32'd63) begin
            failures++;
            $display("[TB] FAIL wd_edge_results: got iter=%0d cyc=%0d required 9/63", done_iter, done_cycles);
        end
        tick();
        checks++;
        if (rounds_completed !== 32'd1 || rounds_aborted !== 16'd1) begin
            failures++;
            $display("[TB] FAIL wd_counts: got completed=%0d aborted=%0d required 1/1", rounds_completed, rounds_aborted);
        end
    endtask

    task automatic test_enable_gate();
        int sb;
        do_reset();
        sb = start_grants.size();
        ctrl_leave_k = 1;
        ctrl_ret_k   = 20;
        ctrl_iter    = 8'd2;
        ctrl_cyc     = 32'd20;
        sched_enable = 1'b1;
        req          = 4'b0011;
        wait_start(20, "en_start");
        repeat (3) tick();
        sched_enable = 1'b0;
        wait_done(100, "en_done");
        req = 4'b0010;
        checks++;
        if (last_done !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL en_done_vec: got %b required 0001", last_done);
        end
        repeat (30) tick();
        checks++;
        if (start_grants.size() - sb != 1 || grant_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL en_gated: got starts=%0d grant_valid=%0d required 1/0", start_grants.size() - sb, grant_valid);
        end
        sched_enable = 1'b1;
        wait_start(20, "en_restart");
        checks++;
        if (start_grants[sb + 1] !== 4'b0010) begin
            failures++;
            $display("[TB] FAIL en_regrant: got %b required 0010", start_grants[sb + 1]);
        end
        wait_done(100, "en_done2");
        req = 4'b0000;
        tick();
    endtask

    task automatic test_async_reset();
        int db;
        ctrl_leave_k = 1;
        ctrl_ret_k   = 40;
        ctrl_iter    = 8'd4;
        ctrl_cyc     = 32'd40;
        sched_enable = 1'b1;
        req          = 4'b0100;
        wait_start(20, "ar_start");
        repeat (10) tick();
        db = done_count;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({grant, grant_valid, new_round_start, decoder_abort, done} !== 11'b0) begin
            failures++;
            $display("[TB] FAIL ar_ctrl: got %b required 0", {grant, grant_valid, new_round_start, decoder_abort, done});
        end
        checks++;
        if (rounds_completed !== 32'd0 || result_cycles !== 32'd0 || result_iterations !== 8'd0) begin
            failures++;
            $display("[TB] FAIL ar_results: got completed=%0d cyc=%0d iter=%0d required 0/0/0", rounds_completed, result_cycles, result_iterations);
        end
        req = 4'b1111;
        tick();
        tick();
        reset = 1'b1;
        wait_start(20, "ar_restart");
        checks++;
        if (done_count != db) begin
            failures++;
            $display("[TB] FAIL ar_no_done: got %0d done pulses required 0", done_count - db);
        end
        checks++;
        if (start_grants[start_grants.size() - 1] !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL ar_first_grant: got %b required 0001", start_grants[start_grants.size() - 1]);
        end
        wait_done(100, "ar_done");
        req = 4'b0000;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_round();
        test_round_robin();
        test_start_timeout();
        test_watchdog();
        test_enable_gate();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
